// File: rtl/axi3_slave_ram_if.sv
// rtl/axi3_slave_ram_if.sv - AXI3 channel bundle between a master and the slave RAM
// Ports: aw* write address, w* write data, b* write response,
//        ar* read address, r* read data; master/slave modports.
interface axi3_slave_ram_if #(
   parameter int AXI_DWIDTH = 64,
   parameter int ID_WIDTH   = 4
);
   localparam int STRB = AXI_DWIDTH / 8;

   logic [ID_WIDTH-1:0]   awid;
   logic [31:0]           awaddr;
   logic [3:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic [1:0]            awlock;
   logic                  awvalid;
   logic                  awready;

   logic [ID_WIDTH-1:0]   wid;
   logic [AXI_DWIDTH-1:0] wdata;
   logic [STRB-1:0]       wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;

   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [ID_WIDTH-1:0]   arid;
   logic [31:0]           araddr;
   logic [3:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic [1:0]            arlock;
   logic                  arvalid;
   logic                  arready;

   logic [ID_WIDTH-1:0]   rid;
   logic [AXI_DWIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awvalid, input awready,
      output wid, wdata, wstrb, wlast, wvalid, input wready,
      input bid, bresp, bvalid, output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arvalid, input arready,
      input rid, rdata, rresp, rlast, rvalid, output rready
   );

   modport slave (
      input awid, awaddr, awlen, awsize, awburst, awlock, awvalid, output awready,
      input wid, wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready,
      input arid, araddr, arlen, arsize, arburst, arlock, arvalid, output arready,
      output rid, rdata, rresp, rlast, rvalid, input rready
   );
endinterface

// File: rtl/axi3_slave_ram.sv
// rtl/axi3_slave_ram.sv - AXI3 slave terminating one write and one read burst into a byte-enabled RAM
// Ports: i_aclk clock, i_areset async active-high reset, s_axi AXI3 slave channels.
module axi3_slave_ram #(
   parameter int AXI_DWIDTH = 64,
   parameter int ID_WIDTH   = 4,
   parameter int MEM_DEPTH  = 256
) (
   input  logic            i_aclk,
   input  logic            i_areset,
   axi3_slave_ram_if.slave s_axi
);
   localparam int STRB   = AXI_DWIDTH / 8;
   localparam int BSHIFT = $clog2(STRB);
   localparam int AW     = $clog2(MEM_DEPTH);
   localparam int HI     = BSHIFT + AW;          // first address bit beyond the RAM
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA} rstate_t;

   logic [AXI_DWIDTH-1:0] r_mem [MEM_DEPTH] = '{default: '0};

   function automatic logic [31:0] f_next_addr(input logic [31:0] addr, input logic [2:0] size,
                                               input logic [1:0] burst, input logic [3:0] len);
      logic [31:0] incr;
      logic [31:0] mask;
      incr = 32'd1 << size;
      mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
      case (burst)
         2'b00:   f_next_addr = addr;
         2'b10:   f_next_addr = (addr & ~mask) | ((addr + incr) & mask);
         default: f_next_addr = addr + incr;   // reserved encoding walks like INCR
      endcase
   endfunction

   function automatic logic f_burst_err(input logic [2:0] size, input logic [1:0] burst,
                                        input logic [3:0] len);
      f_burst_err = (burst == 2'b11) || (size > 3'(BSHIFT)) ||
                    ((burst == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
   endfunction

   // ---------------- write channel ----------------
   wstate_t               r_wstate, w_wstate_nxt;
   logic                  r_awready, r_wready, r_bvalid, r_werr;
   logic [ID_WIDTH-1:0]   r_bid, r_awid;
   logic [1:0]            r_bresp, r_awburst;
   logic [31:0]           r_waddr;
   logic [3:0]            r_awlen, r_wbeat;
   logic [2:0]            r_awsize;
   logic                  w_aw_hs, w_w_hs, w_b_hs, w_wlast_beat, w_woor, w_wbeat_err;
   logic [AW-1:0]         w_widx;

   assign w_widx = r_waddr[HI-1:BSHIFT];

   always_comb begin
      w_wstate_nxt = r_wstate;
      w_aw_hs      = s_axi.awvalid & r_awready;
      w_w_hs       = s_axi.wvalid & r_wready;
      w_b_hs       = r_bvalid & s_axi.bready;
      w_wlast_beat = (r_wbeat == r_awlen);
      w_woor       = |r_waddr[31:HI];
      w_wbeat_err  = w_woor | (s_axi.wlast != w_wlast_beat);
      case (r_wstate)
         W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
         W_DATA:  if (w_w_hs && w_wlast_beat) w_wstate_nxt = W_RESP;
         W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) r_wstate <= W_IDLE;
      else          r_wstate <= w_wstate_nxt;
   end

   // Handshake outputs are registered copies of the next state, so they
   // are low during reset and rise on the first edge after release.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bid     <= '0;
         r_bresp   <= OKAY;
         r_waddr   <= '0;
         r_awid    <= '0;
         r_awlen   <= '0;
         r_awsize  <= '0;
         r_awburst <= '0;
         r_wbeat   <= '0;
         r_werr    <= 1'b0;
      end else begin
         r_awready <= (w_wstate_nxt == W_IDLE);
         r_wready  <= (w_wstate_nxt == W_DATA);
         r_bvalid  <= (w_wstate_nxt == W_RESP);
         if (w_aw_hs) begin
            r_waddr   <= s_axi.awaddr;
            r_awid    <= s_axi.awid;
            r_awlen   <= s_axi.awlen;
            r_awsize  <= s_axi.awsize;
            r_awburst <= s_axi.awburst;
            r_wbeat   <= '0;
            r_werr    <= f_burst_err(s_axi.awsize, s_axi.awburst, s_axi.awlen);
         end
         if (w_w_hs) begin
            r_waddr <= f_next_addr(r_waddr, r_awsize, r_awburst, r_awlen);
            r_wbeat <= r_wbeat + 4'd1;
            r_werr  <= r_werr | w_wbeat_err;
            if (w_wlast_beat) begin
               r_bid   <= r_awid;
               r_bresp <= (r_werr | w_wbeat_err) ? SLVERR : OKAY;
            end
         end
      end
   end

   // RAM contents survive reset; out-of-range beats are dropped rather than aliased.
   always_ff @(posedge i_aclk) begin
      if (w_w_hs && !w_woor) begin
         for (int b = 0; b < STRB; b++) begin
            if (s_axi.wstrb[b]) r_mem[w_widx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
         end
      end
   end

   // ---------------- read channel ----------------
   rstate_t               r_rstate, w_rstate_nxt;
   logic                  r_arready, r_rvalid, r_rlast, r_rerr;
   logic [ID_WIDTH-1:0]   r_rid;
   logic [AXI_DWIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp, r_arburst;
   logic [31:0]           r_raddr, w_rd_addr;
   logic [3:0]            r_arlen, r_rbeat, w_rlen, w_rbeat_nxt;
   logic [2:0]            r_arsize;
   logic                  w_ar_hs, w_r_hs, w_r_load, w_roor, w_rerr_burst;
   logic [AW-1:0]         w_ridx;

   assign w_ridx = w_rd_addr[HI-1:BSHIFT];

   // The beat being loaded comes straight from AR on acceptance, otherwise
   // from the address following the beat currently presented.
   always_comb begin
      w_rstate_nxt = r_rstate;
      w_ar_hs      = s_axi.arvalid & r_arready;
      w_r_hs       = r_rvalid & s_axi.rready;
      w_r_load     = w_ar_hs | (w_r_hs & ~r_rlast);
      if (r_rstate == R_IDLE) begin
         w_rd_addr    = s_axi.araddr;
         w_rlen       = s_axi.arlen;
         w_rbeat_nxt  = '0;
         w_rerr_burst = f_burst_err(s_axi.arsize, s_axi.arburst, s_axi.arlen);
      end else begin
         w_rd_addr    = f_next_addr(r_raddr, r_arsize, r_arburst, r_arlen);
         w_rlen       = r_arlen;
         w_rbeat_nxt  = r_rbeat + 4'd1;
         w_rerr_burst = r_rerr;
      end
      w_roor = |w_rd_addr[31:HI];
      case (r_rstate)
         R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
         R_DATA:  if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) r_rstate <= R_IDLE;
      else          r_rstate <= w_rstate_nxt;
   end

   // RAM is sampled with the pre-edge contents, so a same-cycle write to the
   // same word is not visible to this read.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rid     <= '0;
         r_rdata   <= '0;
         r_rresp   <= OKAY;
         r_raddr   <= '0;
         r_arlen   <= '0;
         r_arsize  <= '0;
         r_arburst <= '0;
         r_rbeat   <= '0;
         r_rerr    <= 1'b0;
      end else begin
         r_arready <= (w_rstate_nxt == R_IDLE);
         r_rvalid  <= (w_rstate_nxt == R_DATA);
         if (w_ar_hs) begin
            r_rid     <= s_axi.arid;
            r_arlen   <= s_axi.arlen;
            r_arsize  <= s_axi.arsize;
            r_arburst <= s_axi.arburst;
            r_rerr    <= w_rerr_burst;
         end
         if (w_r_load) begin
            r_raddr <= w_rd_addr;
            r_rbeat <= w_rbeat_nxt;
            r_rdata <= w_roor ? '0 : r_mem[w_ridx];
            r_rresp <= (w_roor | w_rerr_burst) ? SLVERR : OKAY;
            r_rlast <= (w_rbeat_nxt == w_rlen);
         end else if (w_r_hs) begin
            r_rlast <= 1'b0;
         end
      end
   end

   assign s_axi.awready = r_awready;
   assign s_axi.wready  = r_wready;
   assign s_axi.bvalid  = r_bvalid;
   assign s_axi.bid     = r_bid;
   assign s_axi.bresp   = r_bresp;
   assign s_axi.arready = r_arready;
   assign s_axi.rvalid  = r_rvalid;
   assign s_axi.rid     = r_rid;
   assign s_axi.rdata   = r_rdata;
   assign s_axi.rresp   = r_rresp;
   assign s_axi.rlast   = r_rlast;

   logic w_unused;
   assign w_unused = ^{s_axi.wid, s_axi.awlock, s_axi.arlock};
endmodule

// File: tb/tb_axi3_slave_ram.sv
// tb/tb_axi3_slave_ram.sv - directed self-checking bench for axi3_slave_ram
module tb_axi3_slave_ram;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi3_slave_ram_if #(.AXI_DWIDTH(64), .ID_WIDTH(4)) m ();
   axi3_slave_ram #(.AXI_DWIDTH(64), .ID_WIDTH(4), .MEM_DEPTH(256)) dut (
      .i_aclk(clk), .i_areset(rst), .s_axi(m)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [63:0] wd [16];
   logic [7:0]  ws [16];
   logic [63:0] rd [16];
   logic [1:0]  rr [16];
   logic        rl [16];
   logic [63:0] ex [4];
   logic [1:0]  bresp;
   logic [3:0]  bid;
   int          beat;
   logic        rdy;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      m.awid = id; m.awaddr = addr; m.awlen = len; m.awsize = size; m.awburst = burst;
      m.awvalid = 1'b1;
      while (!m.awready && n < 20) begin tick(); n++; end
      check("aw_ready", 64'(m.awready), 64'd1);
      tick();
      m.awvalid = 1'b0;
   endtask

   task automatic do_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
      int n = 0;
      m.wdata = data; m.wstrb = strb; m.wlast = last; m.wvalid = 1'b1;
      while (!m.wready && n < 20) begin tick(); n++; end
      check("w_ready", 64'(m.wready), 64'd1);
      tick();
      m.wvalid = 1'b0; m.wlast = 1'b0;
   endtask

   task automatic wait_b(input int hold, output logic [1:0] resp, output logic [3:0] id);
      int n = 0;
      m.bready = 1'b0;
      while (!m.bvalid && n < 20) begin tick(); n++; end
      check("b_valid", 64'(m.bvalid), 64'd1);
      for (int d = 0; d < hold; d++) begin
         tick();
         check("b_hold", 64'(m.bvalid), 64'd1);
         check("aw_block", 64'(m.awready), 64'd0);
      end
      resp = m.bresp; id = m.bid;
      m.bready = 1'b1;
      tick();
      m.bready = 1'b0;
      check("b_clear", 64'(m.bvalid), 64'd0);
   endtask

   task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input int early, input int hold);
      do_aw(id, addr, len, size, burst);
      for (int b = 0; b <= int'(len); b++)
         do_w(wd[b], ws[b], (early >= 0) ? (b == early) : (b == int'(len)));
      wait_b(hold, bresp, bid);
   endtask

   task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      m.arid = id; m.araddr = addr; m.arlen = len; m.arsize = size; m.arburst = burst;
      m.arvalid = 1'b1;
      while (!m.arready && n < 20) begin tick(); n++; end
      check("ar_ready", 64'(m.arready), 64'd1);
      tick();
      m.arvalid = 1'b0;
   endtask

   task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
      do_ar(id, addr, len, size, burst);
      check("r_first", 64'(m.rvalid), 64'd1);
      m.rready = 1'b1;
      for (int b = 0; b <= int'(len); b++) begin
         int n = 0;
         while (!m.rvalid && n < 20) begin tick(); n++; end
         rd[b] = m.rdata; rr[b] = m.rresp; rl[b] = m.rlast;
         check("r_id", 64'(m.rid), 64'(id));
         tick();
      end
      m.rready = 1'b0;
      check("r_idle", 64'(m.rvalid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      m.awid = '0; m.awaddr = '0; m.awlen = '0; m.awsize = '0; m.awburst = '0; m.awlock = '0;
      m.awvalid = 1'b0; m.wid = '0; m.wdata = '0; m.wstrb = '0; m.wlast = 1'b0; m.wvalid = 1'b0;
      m.bready = 1'b0; m.arid = '0; m.araddr = '0; m.arlen = '0; m.arsize = '0; m.arburst = '0;
      m.arlock = '0; m.arvalid = 1'b0; m.rready = 1'b0;

      // reset state and release
      repeat (2) @(posedge clk);
      #1;
      check("rst_awready", 64'(m.awready), 64'd0);
      check("rst_wready", 64'(m.wready), 64'd0);
      check("rst_bvalid", 64'(m.bvalid), 64'd0);
      check("rst_arready", 64'(m.arready), 64'd0);
      check("rst_rvalid", 64'(m.rvalid), 64'd0);
      check("rst_rdata", m.rdata, 64'd0);
      rst = 1'b0;
      check("rel_awready_pre", 64'(m.awready), 64'd0);
      tick();
      check("rel_awready", 64'(m.awready), 64'd1);
      check("rel_arready", 64'(m.arready), 64'd1);

      // INCR write, first beat missing byte 0
      for (int b = 0; b < 16; b++) begin wd[b] = 64'haaaa5555aaaa5555; ws[b] = 8'hff; end
      ws[0] = 8'hfe;
      write_burst(4'h5, 32'h10, 4'd3, 3'd3, 2'b01, -1, 0);
      check("incr_bresp", 64'(bresp), 64'd0);
      check("incr_bid", 64'(bid), 64'h5);
      read_burst(4'h6, 32'h10, 4'd3, 3'd3, 2'b01);
      check("incr_rd0", rd[0], 64'haaaa5555aaaa5500);
      for (int b = 1; b < 4; b++) check("incr_rd", rd[b], 64'haaaa5555aaaa5555);
      for (int b = 0; b < 4; b++) check("incr_rlast", 64'(rl[b]), 64'(b == 3));
      check("incr_rresp", 64'(rr[0]), 64'd0);

      // words 0..3 = D(b), then WRAP read from word 3
      for (int b = 0; b < 4; b++) begin wd[b] = {32'hd0d0d0d0, 32'(b)}; ws[b] = 8'hff; end
      write_burst(4'h1, 32'h0, 4'd3, 3'd3, 2'b01, -1, 0);
      check("d_bresp", 64'(bresp), 64'd0);
      read_burst(4'h2, 32'h18, 4'd3, 3'd3, 2'b10);
      check("wrap_rd0", rd[0], {32'hd0d0d0d0, 32'd3});
      check("wrap_rd1", rd[1], {32'hd0d0d0d0, 32'd0});
      check("wrap_rd2", rd[2], {32'hd0d0d0d0, 32'd1});
      check("wrap_rd3", rd[3], {32'hd0d0d0d0, 32'd2});
      check("wrap_rresp", 64'(rr[1]), 64'd0);

      // FIXED burst onto word 5: last beat wins, word 6 untouched
      for (int b = 0; b < 4; b++) wd[b] = {32'he0e0e0e0, 32'(b)};
      write_burst(4'h3, 32'h28, 4'd3, 3'd3, 2'b00, -1, 0);
      check("fixed_bresp", 64'(bresp), 64'd0);
      read_burst(4'h4, 32'h28, 4'd1, 3'd3, 2'b01);
      check("fixed_w5", rd[0], {32'he0e0e0e0, 32'd3});
      check("fixed_w6", rd[1], 64'd0);

      // write to word MEM_DEPTH+1: SLVERR, no alias onto word 1
      wd[0] = 64'hffffffffffffffff;
      write_burst(4'h7, 32'h808, 4'd0, 3'd3, 2'b01, -1, 0);
      check("oor_w_bresp", 64'(bresp), 64'h2);
      read_burst(4'h7, 32'h08, 4'd0, 3'd3, 2'b01);
      check("oor_w_word1", rd[0], {32'hd0d0d0d0, 32'd1});

      // WLAST early on beat 1 of LEN=3
      for (int b = 0; b < 4; b++) wd[b] = 64'(b);
      write_burst(4'h8, 32'h40, 4'd3, 3'd3, 2'b01, 1, 0);
      check("early_bresp", 64'(bresp), 64'h2);

      // read crossing the top of RAM
      read_burst(4'h9, 32'h7f8, 4'd1, 3'd3, 2'b01);
      check("oor_r_resp0", 64'(rr[0]), 64'd0);
      check("oor_r_resp1", 64'(rr[1]), 64'h2);
      check("oor_r_data1", rd[1], 64'd0);

      // BREADY held low for 5 cycles
      wd[0] = 64'h0123456789abcdef;
      write_burst(4'ha, 32'h48, 4'd0, 3'd3, 2'b01, -1, 5);
      check("bdly_bresp", 64'(bresp), 64'd0);
      check("bdly_bid", 64'(bid), 64'ha);
      check("bdly_awready", 64'(m.awready), 64'd1);

      // same-cycle write and read of word 2
      do_aw(4'hb, 32'h10, 4'd0, 3'd3, 2'b01);
      m.wdata = 64'h2222222222222222; m.wstrb = 8'hff; m.wlast = 1'b1; m.wvalid = 1'b1;
      m.arid = 4'hc; m.araddr = 32'h10; m.arlen = 4'd0; m.arsize = 3'd3; m.arburst = 2'b01;
      m.arvalid = 1'b1;
      check("col_wready", 64'(m.wready), 64'd1);
      check("col_arready", 64'(m.arready), 64'd1);
      tick();
      m.wvalid = 1'b0; m.wlast = 1'b0; m.arvalid = 1'b0;
      check("col_rvalid", 64'(m.rvalid), 64'd1);
      check("col_old", m.rdata, {32'hd0d0d0d0, 32'd2});
      m.rready = 1'b1;
      tick();
      m.rready = 1'b0;
      wait_b(0, bresp, bid);
      read_burst(4'hc, 32'h10, 4'd0, 3'd3, 2'b01);
      check("col_new", rd[0], 64'h2222222222222222);

      // RREADY pattern 1,0,0,1 repeating
      ex[0] = {32'hd0d0d0d0, 32'd0}; ex[1] = {32'hd0d0d0d0, 32'd1};
      ex[2] = 64'h2222222222222222;   ex[3] = {32'hd0d0d0d0, 32'd3};
      do_ar(4'hd, 32'h0, 4'd3, 3'd3, 2'b01);
      beat = 0;
      for (int c = 0; c < 40 && beat < 4; c++) begin
         rdy = (c % 4 == 0) || (c % 4 == 3);
         m.rready = rdy;
         check("tog_valid", 64'(m.rvalid), 64'd1);
         check("tog_data", m.rdata, ex[beat]);
         check("tog_last", 64'(m.rlast), 64'(beat == 3));
         if (rdy) beat++;
         tick();
      end
      m.rready = 1'b0;
      check("tog_beats", 64'(beat), 64'd4);
      check("tog_idle", 64'(m.rvalid), 64'd0);

      // reset during beat 2 of a LEN=7 read
      do_ar(4'he, 32'h0, 4'd7, 3'd3, 2'b01);
      m.rready = 1'b1;
      tick();
      tick();
      check("rst_mid_beat2", m.rdata, 64'h2222222222222222);
      rst = 1'b1;
      #1;
      check("rst_mid_rvalid", 64'(m.rvalid), 64'd0);
      check("rst_mid_rdata", m.rdata, 64'd0);
      check("rst_mid_rlast", 64'(m.rlast), 64'd0);
      check("rst_mid_rid", 64'(m.rid), 64'd0);
      check("rst_mid_arready", 64'(m.arready), 64'd0);
      check("rst_mid_awready", 64'(m.awready), 64'd0);
      m.rready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_rel_arready_pre", 64'(m.arready), 64'd0);
      tick();
      check("rst_rel_arready", 64'(m.arready), 64'd1);
      read_burst(4'hf, 32'h28, 4'd0, 3'd3, 2'b01);
      check("rst_after_data", rd[0], {32'he0e0e0e0, 32'd3});
      check("rst_after_resp", 64'(rr[0]), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
